// File: rtl/fd_scan_if.sv
// Bundle of control, SRAM read and corner-stream signals for fd_scan_engine.
// The slave modport is the engine; the master modport is its environment.
interface fd_scan_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned THR_W  = 6,
    parameter int unsigned CNT_W  = 15
);
    logic              start;
    logic [THR_W-1:0]  thres;
    logic [4:0]        arcLen;
    logic [ADDR_W-1:0] sramAddr;
    logic              sramRden;
    logic [PIX_W-1:0]  sramData;
    logic              cornerValid;
    logic              cornerReady;
    logic [ADDR_W-1:0] cornerAddr;
    logic              cornerType;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cornerCount;

    modport slave (
        input  start, thres, arcLen, sramData, cornerReady,
        output sramAddr, sramRden, cornerValid, cornerAddr, cornerType, busy, done, cornerCount
    );

    modport master (
        output start, thres, arcLen, sramData, cornerReady,
        input  sramAddr, sramRden, cornerValid, cornerAddr, cornerType, busy, done, cornerCount
    );
endinterface

// File: rtl/fd_scan_engine.sv
// FAST-N corner scan over a row-major image in single-port SRAM. Each interior pixel
// costs 17 read cycles (centre + 16 circle points), one drain cycle and one evaluate
// cycle; corners are streamed out over a valid/ready handshake.
module fd_scan_engine #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned THR_W  = 6,
    parameter int unsigned CNT_W  = 15
) (
    input logic      clock,
    input logic      reset,
    fd_scan_if.slave bus
);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam logic [XW-1:0] XFirst = XW'(3);
    localparam logic [XW-1:0] XLast  = XW'(IMG_W - 4);
    localparam logic [YW-1:0] YFirst = YW'(3);
    localparam logic [YW-1:0] YLast  = YW'(IMG_H - 4);
    localparam logic [ADDR_W-1:0] RefFirst = ADDR_W'(3 * IMG_W + 3);
    localparam int Wi = int'(IMG_W);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StEval, StOut, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        fcnt_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] ref_addr_q;
    logic [PIX_W-1:0]  ref_pix_q;
    logic [PIX_W-1:0]  adj_q [16];
    logic [THR_W-1:0]  thr_q;
    logic [4:0]        arc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] caddr_q;
    logic              ctype_q;

    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W:0]    hi_sum;
    logic [PIX_W-1:0]  thr_ext, hi, lo;
    logic [15:0]       bright, dark;
    logic              is_bright, is_corner;
    logic              last_pix, pixel_done, start_ok;

    // Linear address offset of circle point idx relative to the centre pixel.
    function automatic int circ_off(input logic [3:0] idx);
        int dx, dy;
        dx = 0;
        dy = 0;
        case (idx)
            4'd0:    begin dx =  0; dy = -3; end
            4'd1:    begin dx =  1; dy = -3; end
            4'd2:    begin dx =  2; dy = -2; end
            4'd3:    begin dx =  3; dy = -1; end
            4'd4:    begin dx =  3; dy =  0; end
            4'd5:    begin dx =  3; dy =  1; end
            4'd6:    begin dx =  2; dy =  2; end
            4'd7:    begin dx =  1; dy =  3; end
            4'd8:    begin dx =  0; dy =  3; end
            4'd9:    begin dx = -1; dy =  3; end
            4'd10:   begin dx = -2; dy =  2; end
            4'd11:   begin dx = -3; dy =  1; end
            4'd12:   begin dx = -3; dy =  0; end
            4'd13:   begin dx = -3; dy = -1; end
            4'd14:   begin dx = -2; dy = -2; end
            default: begin dx = -1; dy = -3; end
        endcase
        return dy * Wi + dx;
    endfunction

    // Longest circular run of ones; the mask is doubled so a run may wrap 15->0.
    function automatic logic [4:0] max_run(input logic [15:0] m);
        logic [31:0] d;
        logic [5:0]  run, best;
        d    = {m, m};
        run  = '0;
        best = '0;
        for (int i = 0; i < 32; i++) begin
            run = d[i] ? run + 6'd1 : 6'd0;
            if (run > best) best = run;
        end
        return (best > 6'd16) ? 5'd16 : best[4:0];
    endfunction

    // Read address: centre on fetch cycle 0, circle point (fcnt-1) afterwards, mod 2^ADDR_W.
    always_comb begin
        rd_addr = ref_addr_q;
        if (fcnt_q != 5'd0) rd_addr = ref_addr_q + ADDR_W'(circ_off(4'(fcnt_q - 5'd1)));
    end

    // Segment test on the captured centre and circle.
    always_comb begin
        thr_ext = PIX_W'(thr_q);
        hi_sum  = {1'b0, ref_pix_q} + {1'b0, thr_ext};
        hi      = hi_sum[PIX_W] ? '1 : hi_sum[PIX_W-1:0];
        lo      = (ref_pix_q >= thr_ext) ? ref_pix_q - thr_ext : '0;
        bright  = '0;
        dark    = '0;
        for (int i = 0; i < 16; i++) begin
            bright[i] = adj_q[i] > hi;
            dark[i]   = adj_q[i] < lo;
        end
        is_bright = max_run(bright) >= arc_q;
        is_corner = is_bright || (max_run(dark) >= arc_q);
    end

    assign last_pix   = (x_q == XLast) && (y_q == YLast);
    assign start_ok   = (state_q == StIdle) && bus.start;
    assign pixel_done = ((state_q == StEval) && !is_corner) ||
                        ((state_q == StOut) && bus.cornerReady);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StFetch;
            StFetch: if (fcnt_q == 5'd16) state_d = StWait;
            StWait:  state_d = StEval;
            StEval: begin
                if (is_corner)     state_d = StOut;
                else if (last_pix) state_d = StDone;
                else               state_d = StFetch;
            end
            StOut:   if (bus.cornerReady) state_d = last_pix ? StDone : StFetch;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Scan position, latched run parameters, result record and corner counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fcnt_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            ref_addr_q <= '0;
            thr_q      <= '0;
            arc_q      <= '0;
            cnt_q      <= '0;
            caddr_q    <= '0;
            ctype_q    <= 1'b0;
        end else begin
            fcnt_q <= (state_q == StFetch) ? fcnt_q + 5'd1 : 5'd0;
            if (start_ok) begin
                x_q        <= XFirst;
                y_q        <= YFirst;
                ref_addr_q <= RefFirst;
                thr_q      <= bus.thres;
                cnt_q      <= '0;
                if (bus.arcLen < 5'd9)       arc_q <= 5'd9;
                else if (bus.arcLen > 5'd16) arc_q <= 5'd16;
                else                         arc_q <= bus.arcLen;
            end
            if (state_q == StEval && is_corner) begin
                caddr_q <= ref_addr_q;
                ctype_q <= is_bright;
            end
            if (state_q == StOut && bus.cornerReady && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (pixel_done && !last_pix) begin
                if (x_q == XLast) begin
                    x_q        <= XFirst;
                    y_q        <= y_q + YW'(1);
                    ref_addr_q <= ref_addr_q + ADDR_W'(7);
                end else begin
                    x_q        <= x_q + XW'(1);
                    ref_addr_q <= ref_addr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Capture read data one cycle after each read: word 0 is the centre, then circle 0..15.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_pix_q <= '0;
            for (int i = 0; i < 16; i++) adj_q[i] <= '0;
        end else if (state_q == StFetch && fcnt_q != 5'd0) begin
            if (fcnt_q == 5'd1) ref_pix_q <= bus.sramData;
            else                adj_q[4'(fcnt_q - 5'd2)] <= bus.sramData;
        end else if (state_q == StWait) begin
            adj_q[15] <= bus.sramData;
        end
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        bus.sramRden    = (state_q == StFetch);
        bus.sramAddr    = (state_q == StFetch) ? rd_addr : '0;
        bus.cornerValid = (state_q == StOut);
        bus.busy        = (state_q != StIdle) && (state_q != StDone);
        bus.done        = (state_q == StDone);
        bus.cornerAddr  = caddr_q;
        bus.cornerType  = ctype_q;
        bus.cornerCount = cnt_q;
    end
endmodule
